iecdrv_debounce: RTL and testbench

Parametrised multi-bit input conditioner for the IEC drive logic: synchronises asynchronous bus and mechanism lines (ATN/CLK/DATA, write-protect, sense switches) into the drive clock domain, rejects glitches shorter than a programmable stable time, and reports clean edges. It generalises the plain two-stage "update when stable" synchroniser. It adds configurable synchroniser depth, a per-bit stability counter gated by a clock enable, asynchronous reset to a defined value, and registered rise/fall pulses. It sits between the top-level IEC/drive pins and the VIA/CIA port inputs.

---
 rtl/iecdrv_debounce.sv | 88 ++++++++
 tb/tb_iecdrv_debounce.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/iecdrv_debounce.sv
// rtl/iecdrv_debounce.sv - synchronising, glitch-rejecting input conditioner with edge pulses
// Per channel: SYNC-flop synchroniser feeding a ce-gated stability counter in front of out.
module iecdrv_debounce #(
  parameter int               WIDTH  = 4,
  parameter int               SYNC   = 2,
  parameter int               STABLE = 4,
  parameter logic [WIDTH-1:0] INIT   = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             any
);
  localparam int              CNTW = (STABLE > 1) ? $clog2(STABLE) : 1;
  localparam logic [CNTW-1:0] LAST = CNTW'(STABLE - 1);
  localparam logic [CNTW-1:0] ONE  = CNTW'(1);

  logic [WIDTH-1:0]            r_sync [SYNC];
  logic [WIDTH-1:0][CNTW-1:0]  r_cnt;
  logic [WIDTH-1:0]            r_out;
  logic [WIDTH-1:0]            r_rise;
  logic [WIDTH-1:0]            r_fall;
  logic                        r_any;

  logic [WIDTH-1:0]            w_y;
  logic [WIDTH-1:0][CNTW-1:0]  w_cnt_nxt;
  logic [WIDTH-1:0]            w_out_nxt;
  logic [WIDTH-1:0]            w_rise;
  logic [WIDTH-1:0]            w_fall;

  assign w_y  = r_sync[SYNC-1];
  assign out  = r_out;
  assign rise = r_rise;
  assign fall = r_fall;
  assign any  = r_any;

  // Synchroniser runs every clk; only the last stage is ever read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < SYNC; k++) r_sync[k] <= INIT;
    end else begin
      r_sync[0] <= in;
      for (int k = 1; k < SYNC; k++) r_sync[k] <= r_sync[k-1];
    end
  end

  always_comb begin
    w_cnt_nxt = r_cnt;
    w_out_nxt = r_out;
    w_rise    = '0;
    w_fall    = '0;
    for (int b = 0; b < WIDTH; b++) begin
      if (ce) begin
        if (w_y[b] == r_out[b]) begin
          w_cnt_nxt[b] = '0;
        end else if (r_cnt[b] == LAST) begin
          w_cnt_nxt[b] = '0;
          w_out_nxt[b] = w_y[b];
          w_rise[b]    = w_y[b];
          w_fall[b]    = ~w_y[b];
        end else begin
          w_cnt_nxt[b] = r_cnt[b] + ONE;
        end
      end
    end
  end

  // Pulses are registered alongside out so they coincide with the new level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt  <= '0;
      r_out  <= INIT;
      r_rise <= '0;
      r_fall <= '0;
      r_any  <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_out  <= w_out_nxt;
      r_rise <= w_rise;
      r_fall <= w_fall;
      r_any  <= |(w_rise | w_fall);
    end
  end
endmodule

// File: tb/tb_iecdrv_debounce.sv
// tb/tb_iecdrv_debounce.sv - scoreboard bench for iecdrv_debounce
// Three instances: defaults with INIT=1010, WIDTH=1/SYNC=4/STABLE=1, WIDTH=32/STABLE=255.
module tb_iecdrv_debounce;
  typedef struct {
    int          cyc;
    logic [31:0] o;
    logic [31:0] r;
    logic [31:0] f;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        ce = 1'b1;
  logic        ce_one;
  logic        ce_strobe = 1'b0;
  logic [3:0]  in0, out0, rise0, fall0;
  logic        any0;
  logic [0:0]  in1, out1, rise1, fall1;
  logic        any1;
  logic [31:0] in2, out2, rise2, fall2;
  logic        any2;
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  exp_t        q [3][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // Strobe mode: ce is high only for edges whose number is a multiple of 10.
  always @(negedge clk) ce = ce_strobe ? ((cyc % 10) == 9) : 1'b1;

  iecdrv_debounce #(.WIDTH(4), .SYNC(2), .STABLE(4), .INIT(4'b1010)) u_d0 (
    .clk(clk), .reset(reset), .ce(ce), .in(in0),
    .out(out0), .rise(rise0), .fall(fall0), .any(any0));
  iecdrv_debounce #(.WIDTH(1), .SYNC(4), .STABLE(1), .INIT(1'b0)) u_d1 (
    .clk(clk), .reset(reset), .ce(ce_one), .in(in1),
    .out(out1), .rise(rise1), .fall(fall1), .any(any1));
  iecdrv_debounce #(.WIDTH(32), .SYNC(2), .STABLE(255), .INIT(32'h0)) u_d2 (
    .clk(clk), .reset(reset), .ce(ce_one), .in(in2),
    .out(out2), .rise(rise2), .fall(fall2), .any(any2));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input int id, input int lat, input logic [31:0] o, input logic [31:0] r, input logic [31:0] f);
    exp_t e;
    e.cyc = cyc + lat;
    e.o = o;
    e.r = r;
    e.f = f;
    q[id].push_back(e);
  endtask

  task automatic mon(input int id, input logic [31:0] o, input logic [31:0] r, input logic [31:0] f, input logic a);
    exp_t e;
    if (a || r != 0 || f != 0) begin
      if (q[id].size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL d%0d unexpected pulse: cyc %0d rise %0h fall %0h any %0b, expected none", id, cyc, r, f, a);
      end else begin
        e = q[id].pop_front();
        check($sformatf("d%0d pulse cycle", id), 64'(cyc), 64'(e.cyc));
        check($sformatf("d%0d out", id), 64'(o), 64'(e.o));
        check($sformatf("d%0d rise", id), 64'(r), 64'(e.r));
        check($sformatf("d%0d fall", id), 64'(f), 64'(e.f));
        check($sformatf("d%0d any", id), 64'(a), 64'd1);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, 32'(out0), 32'(rise0), 32'(fall0), any0);
    mon(1, 32'(out1), 32'(rise1), 32'(fall1), any1);
    mon(2, out2, rise2, fall2, any2);
  end

  initial begin
    reset = 1'b1;
    in0 = 4'b0101;
    in1 = 1'b0;
    in2 = 32'h0;
    ce_one = 1'b1;
    step(3);
    check("reset out0", 64'(out0), 64'hA);
    check("reset rise0", 64'(rise0), 64'h0);
    check("reset fall0", 64'(fall0), 64'h0);
    check("reset any0", 64'(any0), 64'h0);
    check("reset out2", 64'(out2), 64'h0);

    reset = 1'b0;
    push(0, 6, 32'h5, 32'h5, 32'hA);
    step(10);
    in0 = 4'b0000;
    push(0, 6, 32'h0, 32'h0, 32'h5);
    step(10);
    in0 = 4'b0001;
    push(0, 6, 32'h1, 32'h1, 32'h0);
    step(10);

    // 3-cycle glitch on bit 1 must be absorbed.
    in0 = 4'b0011;
    step(3);
    in0 = 4'b0001;
    step(10);
    check("glitch out0", 64'(out0), 64'h1);
    in0 = 4'b0011;
    push(0, 6, 32'h3, 32'h2, 32'h0);
    step(4);
    in0 = 4'b0001;
    push(0, 6, 32'h1, 32'h0, 32'h2);
    step(12);

    ce_strobe = 1'b1;
    for (int i = 0; i < 20 && (cyc % 10) != 3; i++) @(negedge clk);
    in0 = 4'b0101;
    push(0, 37, 32'h5, 32'h4, 32'h0);
    step(30);
    check("ce partial out0", 64'(out0), 64'h1);
    step(15);
    ce_strobe = 1'b0;
    step(3);

    // Reset with bit 3 two counts into a change.
    in0 = 4'b1101;
    step(4);
    reset = 1'b1;
    #1;
    check("async reset out0", 64'(out0), 64'hA);
    check("async reset rise0", 64'(rise0), 64'h0);
    check("async reset fall0", 64'(fall0), 64'h0);
    step(3);
    reset = 1'b0;
    push(0, 6, 32'hD, 32'h5, 32'h2);
    step(12);

    in1 = 1'b1;
    push(1, 5, 32'h1, 32'h1, 32'h0);
    step(8);
    in1 = 1'b0;
    push(1, 5, 32'h0, 32'h0, 32'h1);
    step(8);

    // 254 mismatched cycles: counter tops out at STABLE-1 without switching.
    in2 = 32'h0000_0100;
    step(254);
    in2 = 32'h0;
    step(270);
    check("stable-1 out2", 64'(out2), 64'h0);
    in2 = 32'hF0F0_00FF;
    push(2, 257, 32'hF0F0_00FF, 32'hF0F0_00FF, 32'h0);
    step(265);
    in2 = 32'h0F0F_00FF;
    push(2, 257, 32'h0F0F_00FF, 32'h0F0F_0000, 32'hF0F0_0000);
    step(265);

    check("d0 queue drained", 64'(q[0].size()), 64'd0);
    check("d1 queue drained", 64'(q[1].size()), 64'd0);
    check("d2 queue drained", 64'(q[2].size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
